// File: rtl/eth_rmii_rx_pkg.sv
// eth_rmii_rx_pkg
//   Constants shared by the RMII receive front-end and the downstream frame
//   parser: preamble/SFD dibit codes, default length limits and the 2-bit
//   receive state encoding.
package eth_rmii_rx_pkg;

  localparam logic [1:0] DIBIT_PRE   = 2'b01;  // preamble dibit
  localparam logic [1:0] DIBIT_SFD   = 2'b11;  // final SFD dibit
  localparam logic [1:0] DIBIT_FALSE = 2'b10;  // false-carrier indication

  localparam int MAX_BYTES_DEF     = 1522;     // bytes after SFD incl. FCS
  localparam int MIN_PRE_DIBIT_DEF = 8;        // preamble dibits before SFD

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_DROP     = 2'd3
  } rx_state_t;

endpackage

// File: rtl/eth_rmii_crs_decode.sv
// eth_rmii_crs_decode
//   Two-stage input pipe on the RMII pins plus CRS_DV interpretation.
// Ports
//   clk         in   RMII REF_CLK
//   rst_n       in   asynchronous active-low reset
//   rxd         in   raw receive dibit from the pins
//   crs_dv      in   raw carrier sense / data valid from the pins
//   dibit       out  dibit at the decision stage (s2)
//   live        out  s2 dibit carries data
//   carrier_end out  two consecutive low CRS_DV samples at s1/s2
module eth_rmii_crs_decode (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] rxd,
  input  logic       crs_dv,
  output logic [1:0] dibit,
  output logic       live,
  output logic       carrier_end
);

  logic [2:0] s1;
  logic [2:0] s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 3'd0;
      s2 <= 3'd0;
    end else begin
      s1 <= {crs_dv, rxd};
      s2 <= s1;
    end
  end

  // At the frame tail the PHY toggles CRS_DV per nibble while data is still
  // valid, so a single low sample must not end the frame; look one stage ahead.
  assign dibit       = s2[1:0];
  assign live        = s2[2] | s1[2];
  assign carrier_end = ~live;

endmodule

// File: rtl/eth_rmii_rx_deser.sv
// eth_rmii_rx_deser
//   RMII receive front-end: strips preamble/SFD and packs dibits (LSB first)
//   into bytes with frame start/end/error strobes.
// Ports
//   clk          in   50 MHz RMII REF_CLK
//   rst_n        in   asynchronous active-low reset
//   rxd[1:0]     in   RMII receive dibit
//   crs_dv       in   RMII carrier sense / data valid
//   byte_data    out  assembled byte, holds between strobes
//   byte_valid   out  1-cycle strobe per byte
//   frame_start  out  with byte_valid of the first byte after SFD
//   frame_end    out  1-cycle strobe, frame closed
//   frame_err    out  qualifies frame_end: alignment or overlength
//   frame_len    out  bytes emitted in frame, valid with frame_end
module eth_rmii_rx_deser
  import eth_rmii_rx_pkg::*;
#(
  parameter int MAX_BYTES     = MAX_BYTES_DEF,
  parameter int MIN_PRE_DIBIT = MIN_PRE_DIBIT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  rxd,
  input  logic        crs_dv,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  output logic        frame_start,
  output logic        frame_end,
  output logic        frame_err,
  output logic [15:0] frame_len
);

  localparam int          PRE_W   = $clog2(MIN_PRE_DIBIT + 1);
  localparam logic [PRE_W-1:0] PRE_MIN = PRE_W'(MIN_PRE_DIBIT);
  localparam logic [15:0] MAX_LEN = 16'(MAX_BYTES);

  logic [1:0]       dibit;
  logic             live;
  logic             carrier_end;

  rx_state_t        state;
  logic [PRE_W-1:0] pre_cnt;
  logic [1:0]       dibit_cnt;
  logic [15:0]      byte_cnt;
  logic [7:0]       shift;

  eth_rmii_crs_decode u_crs_decode (
    .clk         (clk),
    .rst_n       (rst_n),
    .rxd         (rxd),
    .crs_dv      (crs_dv),
    .dibit       (dibit),
    .live        (live),
    .carrier_end (carrier_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pre_cnt     <= '0;
      dibit_cnt   <= 2'd0;
      byte_cnt    <= 16'd0;
      shift       <= 8'd0;
      byte_data   <= 8'd0;
      byte_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_err   <= 1'b0;
      frame_len   <= 16'd0;
    end else begin
      byte_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_err   <= 1'b0;
      if (carrier_end) begin
        // Only a frame that made it past SFD gets closed; any pending
        // dibits mean the frame ended off a byte boundary.
        if (state == ST_DATA) begin
          frame_end <= 1'b1;
          frame_len <= byte_cnt;
          frame_err <= (dibit_cnt != 2'd0);
        end
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (dibit == DIBIT_PRE) begin
              state   <= ST_PREAMBLE;
              pre_cnt <= PRE_W'(1);
            end else if (dibit == DIBIT_FALSE) begin
              state <= ST_DROP;
            end
          end
          ST_PREAMBLE: begin
            if (dibit == DIBIT_PRE) begin
              if (pre_cnt != PRE_MIN) pre_cnt <= pre_cnt + PRE_W'(1);
            end else if (dibit == DIBIT_SFD && pre_cnt >= PRE_MIN) begin
              state     <= ST_DATA;
              dibit_cnt <= 2'd0;
              byte_cnt  <= 16'd0;
            end else begin
              state <= ST_DROP;
            end
          end
          ST_DATA: begin
            shift     <= {dibit, shift[7:2]};
            dibit_cnt <= dibit_cnt + 2'd1;
            if (dibit_cnt == 2'd3) begin
              if (byte_cnt == MAX_LEN) begin
                // Completed byte would exceed the limit: swallow it and
                // close the frame as overlength.
                frame_end <= 1'b1;
                frame_err <= 1'b1;
                frame_len <= MAX_LEN;
                state     <= ST_DROP;
              end else begin
                byte_valid  <= 1'b1;
                byte_data   <= {dibit, shift[7:2]};
                frame_start <= (byte_cnt == 16'd0);
                byte_cnt    <= byte_cnt + 16'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
